// File: rtl/vram_text_reader.sv
// ============================================================================
// Module      : vram_text_reader
// Description : Pixel-request pipeline for the text VRAM read port. It fetches
//               the character code and the glyph row, then emits one pixel
//               with a blinking block cursor overlaid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_text_reader #(
    parameter int COLS         = 60,
    parameter int ROWS         = 17,
    parameter int VRAM_LAT     = 2,
    parameter int FONT_LAT     = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        MEMORY_CLK,
    input  logic        RST_n,
    input  logic        req_valid,
    input  logic [8:0]  req_x,
    input  logic [8:0]  req_y,
    input  logic        frame_start,
    input  logic        cursor_en,
    input  logic [5:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    output logic        v_ceb,
    output logic        v_oce,
    output logic        v_resetb,
    output logic [9:0]  v_adb,
    input  logic [7:0]  v_dout,
    output logic        font_ce,
    output logic [11:0] font_adr,
    input  logic [7:0]  font_dout,
    output logic        pix_valid,
    output logic        pix_on,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y
);

    // Sideband stage s is loaded on the (s)th edge after the request. The font
    // address is built from stage VRAM_LAT and the pixel from the last stage.
    localparam int c_DEPTH     = VRAM_LAT + FONT_LAT + 2;
    localparam int c_FONT_STG  = VRAM_LAT;
    localparam int c_OUT_STG   = c_DEPTH - 1;
    localparam int c_BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_BW-1:0] c_BLINK_LAST = c_BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]      c_COLS7      = 7'(COLS);
    localparam logic [5:0]      c_ROWS6      = 6'(ROWS);
    localparam logic [9:0]      c_COLS10     = 10'(COLS);

    logic [5:0] w_col;
    logic [4:0] w_row;
    logic [9:0] w_row10;
    logic [9:0] w_addr;
    logic       w_in_range;
    logic       w_cursor_hit;
    logic       w_font_ld;

    logic            r_blink_phase;
    logic [c_BW-1:0] r_blink_cnt;

    logic       r_sb_valid [c_DEPTH];
    logic       r_sb_inr   [c_DEPTH];
    logic       r_sb_hit   [c_DEPTH];
    logic [2:0] r_sb_bit   [c_DEPTH];
    logic [8:0] r_sb_x     [c_DEPTH];
    logic [8:0] r_sb_y     [c_DEPTH];

    logic        r_v_ceb;
    logic [9:0]  r_v_adb;
    logic        r_font_ce;
    logic [11:0] r_font_adr;
    logic        r_pix_valid;
    logic        r_pix_on;
    logic [8:0]  r_pix_x;
    logic [8:0]  r_pix_y;

    assign w_col        = req_x[8:3];
    assign w_row        = req_y[8:4];
    assign w_row10      = {5'd0, w_row};
    assign w_in_range   = ({1'b0, w_col} < c_COLS7) && ({1'b0, w_row} < c_ROWS6);
    assign w_cursor_hit = cursor_en && r_blink_phase &&
                          (w_col == cursor_col) && (w_row == cursor_row);

    generate
        if (COLS == 60) begin : g_addr_shift
            assign w_addr = (w_row10 << 6) - (w_row10 << 2) + {4'd0, w_col};
        end else begin : g_addr_mul
            assign w_addr = (w_row10 * c_COLS10) + {4'd0, w_col};
        end
    endgenerate

    always_ff @(posedge MEMORY_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (r_blink_cnt == c_BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge MEMORY_CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_sb_valid[i] <= 1'b0;
                r_sb_inr[i]   <= 1'b0;
                r_sb_hit[i]   <= 1'b0;
                r_sb_bit[i]   <= 3'd0;
                r_sb_x[i]     <= 9'd0;
                r_sb_y[i]     <= 9'd0;
            end
        end else begin
            r_sb_valid[0] <= req_valid;
            r_sb_inr[0]   <= w_in_range;
            r_sb_hit[0]   <= w_cursor_hit;
            r_sb_bit[0]   <= req_x[2:0];
            r_sb_x[0]     <= req_x;
            r_sb_y[0]     <= req_y;
            for (int i = 1; i < c_DEPTH; i++) begin
                r_sb_valid[i] <= r_sb_valid[i-1];
                r_sb_inr[i]   <= r_sb_inr[i-1];
                r_sb_hit[i]   <= r_sb_hit[i-1];
                r_sb_bit[i]   <= r_sb_bit[i-1];
                r_sb_x[i]     <= r_sb_x[i-1];
                r_sb_y[i]     <= r_sb_y[i-1];
            end
        end
    end

    assign w_font_ld = r_sb_valid[c_FONT_STG] && r_sb_inr[c_FONT_STG];

    always_ff @(posedge MEMORY_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_v_ceb     <= 1'b0;
            r_v_adb     <= 10'd0;
            r_font_ce   <= 1'b0;
            r_font_adr  <= 12'd0;
            r_pix_valid <= 1'b0;
            r_pix_on    <= 1'b0;
            r_pix_x     <= 9'd0;
            r_pix_y     <= 9'd0;
        end else begin
            r_v_ceb <= req_valid && w_in_range;
            if (req_valid && w_in_range) begin
                r_v_adb <= w_addr;
            end
            r_font_ce <= w_font_ld;
            if (w_font_ld) begin
                r_font_adr <= {v_dout, r_sb_y[c_FONT_STG][3:0]};
            end
            r_pix_valid <= r_sb_valid[c_OUT_STG];
            if (r_sb_valid[c_OUT_STG]) begin
                // Bit 7 is the leftmost pixel; out-of-range cells stay dark.
                r_pix_on <= r_sb_inr[c_OUT_STG] &&
                            (font_dout[~r_sb_bit[c_OUT_STG]] ^ r_sb_hit[c_OUT_STG]);
                r_pix_x  <= r_sb_x[c_OUT_STG];
                r_pix_y  <= r_sb_y[c_OUT_STG];
            end
        end
    end

    assign v_oce     = 1'b1;
    assign v_resetb  = 1'b0;
    assign v_ceb     = r_v_ceb;
    assign v_adb     = r_v_adb;
    assign font_ce   = r_font_ce;
    assign font_adr  = r_font_adr;
    assign pix_valid = r_pix_valid;
    assign pix_on    = r_pix_on;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;

endmodule

`default_nettype wire
